// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO family.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_DEPTH      = 16;

  // Address bits plus one wrap bit, so full and empty can be told apart.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [ptr_width(DEF_DEPTH)-1:0] count_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH dual-port storage for sync_fifo_param.
// Read port is registered by default; combinational when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_rd;
  assign unused_rd = ^{rst_n, re};
  assign rdata     = mem[raddr];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned AFULL_TH   = DEPTH - 2,
  parameter int unsigned AEMPTY_TH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          winc,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic                          wfull,
  input  logic                          rinc,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          rempty,
  output logic [ptr_width(DEPTH)-1:0]   count,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clr_err
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam logic [PW-1:0] AF_TH = PW'(AFULL_TH);
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_TH);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_TH > DEPTH || AEMPTY_TH >= DEPTH)
  begin : g_param_check
    $fatal(1, "sync_fifo_param: illegal DEPTH/AFULL_TH/AEMPTY_TH");
  end

  logic [PW-1:0] wptr, rptr;
  logic          wr_ok, rd_ok;

  assign rempty = (wptr == rptr);
  assign wfull  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr_ok  = winc && !wfull;
  assign rd_ok  = rinc && !rempty;

  // Wrap-bit pointer difference is the occupancy, so count never drifts from the flags.
  assign count        = wptr - rptr;
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      if (rd_ok) rptr <= rptr + PW'(1);
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull) overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;
      if (rinc && rempty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wptr[AW-1:0]),
    .wdata (wdata),
    .re    (rd_ok),
    .raddr (rptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (DEPTH=16, AFULL_TH=14, AEMPTY_TH=2).
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc, rinc, clr_err;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  sync_fifo_param #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .AFULL_TH   (14),
    .AEMPTY_TH  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .wdata        (wdata),
    .wfull        (wfull),
    .rinc         (rinc),
    .rdata        (rdata),
    .rempty       (rempty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk1({tag, "_rempty"}, rempty, 1'b1);
    chk1({tag, "_wfull"}, wfull, 1'b0);
    chkv({tag, "_count"}, 32'(count), 32'd0);
    chk1({tag, "_aempty"}, almost_empty, 1'b1);
    chk1({tag, "_afull"}, almost_full, 1'b0);
    chk1({tag, "_ovf"}, overflow, 1'b0);
    chk1({tag, "_udf"}, underflow, 1'b0);
`ifndef SYNC_FIFO_FWFT_EN
    chkv({tag, "_rdata"}, 32'(rdata), 32'd0);
`endif
  endtask

  // Pop one word and check it: FWFT sees the head before the edge, standard after.
  task automatic pop_check(input string tag, input logic [7:0] exp);
    rinc = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    chkv(tag, 32'(rdata), 32'(exp));
    tick();
`else
    tick();
    chkv(tag, 32'(rdata), 32'(exp));
`endif
    rinc = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wdata = '0;
    tick(); tick();
    chk_reset_state("reset");
    rst_n = 1'b1;
    tick(); tick();
    chk_reset_state("idle");

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 8'(i);
      tick();
      chkv("fill_count", 32'(count), 32'(i + 1));
      chk1("fill_afull", almost_full, logic'(i + 1 >= 14));
      chk1("fill_aempty", almost_empty, logic'(i + 1 <= 2));
      chk1("fill_wfull", wfull, logic'(i == 15));
    end
    wdata = 8'hAA;
    tick();
    winc = 1'b0;
    chkv("ovf_count", 32'(count), 32'd16);
    chk1("ovf_flag", overflow, 1'b1);
    chk1("ovf_wfull", wfull, 1'b1);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      pop_check("drain_data", 8'(i));
      chkv("drain_count", 32'(count), 32'(15 - i));
    end
    chk1("drain_rempty", rempty, 1'b1);
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    chk1("udf_flag", underflow, 1'b1);
    chk1("udf_ovf_sticky", overflow, 1'b1);
    chkv("udf_count", 32'(count), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chkv("udf_rdata_hold", 32'(rdata), 32'h0F);
`endif
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk1("clr_ovf", overflow, 1'b0);
    chk1("clr_udf", underflow, 1'b0);

    // Concurrent traffic at count=5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      winc = 1'b1; wdata = 8'(8'h20 + i);
      tick();
    end
    winc = 1'b0;
    chkv("conc_pre_count", 32'(count), 32'd5);
    for (int k = 0; k < 20; k++) begin
      winc = 1'b1; wdata = 8'(8'h25 + k);
      pop_check("conc_data", 8'(8'h20 + k));
      chkv("conc_count", 32'(count), 32'd5);
    end
    winc = 1'b0;

    // Fill to full behind 0x34..0x38
    for (int j = 0; j < 11; j++) begin
      winc = 1'b1; wdata = 8'(8'h40 + j);
      tick();
    end
    winc = 1'b0;
    chk1("full2_wfull", wfull, 1'b1);

    // Full + winc + rinc: read wins, write rejected
    winc = 1'b1; wdata = 8'hEE;
    pop_check("fullrw_data", 8'h34);
    winc = 1'b0;
    chkv("fullrw_count", 32'(count), 32'd15);
    chk1("fullrw_ovf", overflow, 1'b1);
    chk1("fullrw_wfull", wfull, 1'b0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk1("fullrw_clr", overflow, 1'b0);
    for (int k = 0; k < 15; k++) begin
      pop_check("drain2_data", (k < 4) ? 8'(8'h35 + k) : 8'(8'h40 + k - 4));
    end
    chk1("drain2_rempty", rempty, 1'b1);

    // Empty + winc + rinc: write wins, read rejected
    winc = 1'b1; rinc = 1'b1; wdata = 8'h77;
    tick();
    winc = 1'b0; rinc = 1'b0;
    chkv("emptyrw_count", 32'(count), 32'd1);
    chk1("emptyrw_udf", underflow, 1'b1);
    chk1("emptyrw_rempty", rempty, 1'b0);
    pop_check("emptyrw_data", 8'h77);

    // clr_err together with a fresh underflow keeps the flag set
    clr_err = 1'b1; rinc = 1'b1;
    tick();
    clr_err = 1'b0; rinc = 1'b0;
    chk1("setwins_udf", underflow, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk1("clr2_udf", underflow, 1'b0);

    // Async reset mid-cycle with count=9
    for (int j = 0; j < 9; j++) begin
      winc = 1'b1; wdata = 8'(8'h90 + j);
      tick();
    end
    winc = 1'b0;
    chkv("pre_rst_count", 32'(count), 32'd9);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    #1 rst_n = 1'b1;
    winc = 1'b1; wdata = 8'hA0;
    tick();
    chkv("post_rst_count", 32'(count), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
    chkv("fwft_fallthrough", 32'(rdata), 32'hA0);
`endif
    wdata = 8'hA1;
    tick();
    winc = 1'b0;
    pop_check("post_rst_data0", 8'hA0);
    pop_check("post_rst_data1", 8'hA1);
    chk1("post_rst_rempty", rempty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
